// File: rtl/spectrum_accumulator.sv
// spectrum_accumulator
//   Accumulates |X[k]|^2 = re*re + im*im over a programmable number of FFT
//   frames into a NofBins x 40-bit RAM, then reads out every bin once as
//   (acc >> shift), saturated to 32 bits.
//
// Ports
//   clk_i          single clock
//   rst_i          synchronous active-high reset
//   re_i, im_i     signed FFT bin sample, qualified by dv_i
//   dv_i           sample valid
//   index_i        bin index of the sample
//   start_i        arms one accumulation run (accepted only in IDLE)
//   nof_frames_i   frames to accumulate (0 means 1), sampled on start
//   shift_i        output right shift (clamped to 8), sampled on start
//   y_hi_o, y_lo_o output bin value bits [31:16] / [15:0]
//   dv_o           output valid, NofBins consecutive cycles per run
//   sof_o          marks bin 0 of the readout
//   busy_o         state is not IDLE
//   err_o          sticky sequence / overrun error, cleared on start
module spectrum_accumulator #(
    parameter int unsigned NofBits = 16,
    parameter int unsigned NofBins = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [NofBits-1:0]  re_i,
    input  logic signed [NofBits-1:0]  im_i,
    input  logic                       dv_i,
    input  logic [$clog2(NofBins)-1:0] index_i,
    input  logic                       start_i,
    input  logic [7:0]                 nof_frames_i,
    input  logic [3:0]                 shift_i,
    output logic [15:0]                y_hi_o,
    output logic [15:0]                y_lo_o,
    output logic                       dv_o,
    output logic                       sof_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned IdxW = $clog2(NofBins);
    localparam int unsigned PwrW = 2 * NofBits;
    localparam int unsigned AccW = 40;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NofBins - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_READOUT
    } state_t;

    state_t state_q;

    // run configuration
    logic [7:0]      nof_q;
    logic [3:0]      shift_q;
    logic [7:0]      frame_q;
    logic [IdxW-1:0] exp_q;
    logic            err_q;

    // write stage of the read-modify-write pipeline
    logic            v1_q;
    logic [IdxW-1:0] a1_q;
    logic [PwrW-1:0] p1_q;
    logic            ovw1_q;

    // readout address generator and read stage
    logic [IdxW-1:0] rcnt_q;
    logic            rd_act_q;
    logic            r1_q;
    logic            r1_first_q;
    logic            r1_last_q;

    // registered outputs
    logic [31:0]     y_q;
    logic            dv_q;
    logic            sof_q;
    logic            last_q;

    // accumulator RAM and its read port
    logic [AccW-1:0] acc_mem [NofBins];
    logic [AccW-1:0] rd_data_q;
    logic            fwd_q;
    logic [AccW-1:0] fwd_data_q;

    logic signed [PwrW-1:0] re_x;
    logic signed [PwrW-1:0] im_x;
    logic [PwrW-1:0]        pwr_d;
    logic [IdxW-1:0]        rd_addr;
    logic [AccW-1:0]        acc_rd;
    logic [AccW-1:0]        wdata;
    logic [AccW-1:0]        shifted;
    logic [31:0]            y_d;

    always_comb begin
        // squares are non-negative, so the sum fits PwrW bits unsigned
        re_x    = PwrW'(re_i);
        im_x    = PwrW'(im_i);
        pwr_d   = re_x * re_x + im_x * im_x;

        rd_addr = (state_q == S_READOUT) ? rcnt_q : index_i;

        // A read issued on the same edge as a write to the same address
        // returns stale data; the write value is captured alongside and
        // substituted here, so repeated indices accumulate correctly.
        acc_rd  = fwd_q ? fwd_data_q : rd_data_q;
        wdata   = ovw1_q ? AccW'(p1_q) : acc_rd + AccW'(p1_q);

        shifted = acc_rd >> shift_q;
        y_d     = (|shifted[AccW-1:32]) ? '1 : shifted[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (v1_q && !rst_i) begin
            acc_mem[a1_q] <= wdata;
        end
        rd_data_q  <= acc_mem[rd_addr];
        fwd_q      <= v1_q && (a1_q == rd_addr);
        fwd_data_q <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            rcnt_q   <= '0;
            rd_act_q <= 1'b0;
            r1_q     <= 1'b0;
            y_q      <= '0;
            dv_q     <= 1'b0;
            sof_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            v1_q   <= 1'b0;
            r1_q   <= 1'b0;
            dv_q   <= r1_q;
            sof_q  <= r1_q && r1_first_q;
            last_q <= r1_q && r1_last_q;
            if (r1_q) begin
                y_q <= y_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        nof_q   <= (nof_frames_i == 8'd0) ? 8'd1 : nof_frames_i;
                        shift_q <= (shift_i > 4'd8) ? 4'd8 : shift_i;
                        err_q   <= 1'b0;
                        frame_q <= '0;
                        exp_q   <= '0;
                        state_q <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (dv_i) begin
                        v1_q   <= 1'b1;
                        a1_q   <= index_i;
                        p1_q   <= pwr_d;
                        ovw1_q <= (frame_q == 8'd0);
                        if (index_i != exp_q) begin
                            err_q <= 1'b1;
                        end
                        exp_q <= index_i + 1'b1;
                        if (index_i == LastIdx) begin
                            frame_q <= frame_q + 8'd1;
                            // The final write still sits in the write stage
                            // when readout starts; forwarding covers it.
                            if ((frame_q + 8'd1) == nof_q) begin
                                state_q  <= S_READOUT;
                                rcnt_q   <= '0;
                                rd_act_q <= 1'b1;
                            end
                        end
                    end
                end

                S_READOUT: begin
                    if (dv_i) begin
                        err_q <= 1'b1;
                    end
                    if (rd_act_q) begin
                        r1_q       <= 1'b1;
                        r1_first_q <= (rcnt_q == '0);
                        r1_last_q  <= (rcnt_q == LastIdx);
                        rcnt_q     <= rcnt_q + 1'b1;
                        if (rcnt_q == LastIdx) begin
                            rd_act_q <= 1'b0;
                        end
                    end
                    if (last_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign y_hi_o = y_q[31:16];
    assign y_lo_o = y_q[15:0];
    assign dv_o   = dv_q;
    assign sof_o  = sof_q;
    assign busy_o = (state_q != S_IDLE);
    assign err_o  = err_q;

endmodule

// File: doc/spectrum_accumulator.md
SPECTRUM_ACCUMULATOR -- requirements
Module: spectrum_accumulator

Interface
REQ-001 Parameter NofBits, default 16: width of the signed real/imaginary FFT input samples.
REQ-002 Parameter NofBins, default 1024: bins per FFT frame; the value SHALL be a power of two; the index width is log2(NofBins).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk_i, input, 1: the single clock for all logic.
REQ-005 Port rst_i, input, 1: synchronous active-high reset.
REQ-006 Port re_i, input, NofBits: signed real part of the FFT output bin.
REQ-007 Port im_i, input, NofBits: signed imaginary part of the FFT output bin.
REQ-008 Port dv_i, input, 1: qualifies re_i, im_i and index_i for one cycle.
REQ-009 Port index_i, input, log2(NofBins): bin index of the current sample.
REQ-010 Port start_i, input, 1: single-cycle pulse that arms one accumulation run.
REQ-011 Port nof_frames_i, input, 8: number of frames to accumulate; 0 is treated as 1; sampled on the accepted start_i.
REQ-012 Port shift_i, input, 4: output right-shift; values above 8 are treated as 8; sampled on the accepted start_i.
REQ-013 Port y_hi_o, output, 16: bits [31:16] of the output bin value.
REQ-014 Port y_lo_o, output, 16: bits [15:0] of the output bin value.
REQ-015 Port dv_o, output, 1: y_hi_o and y_lo_o are valid.
REQ-016 Port sof_o, output, 1: high with dv_o for bin 0 only.
REQ-017 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-018 Port err_o, output, 1: sticky flag for a sequence or overrun error; cleared on an accepted start_i.

Function
REQ-019 The block SHALL implement three states: IDLE, ACCUM and READOUT.
REQ-020 IDLE: start_i SHALL latch the configuration, clear err_o, reset the frame counter to 0, set the expected index to 0 and move to ACCUM.
REQ-021 IDLE: dv_i SHALL be ignored, with no error.
REQ-022 Power per sample SHALL be re*re + im*im, computed unsigned in 32 bits; the maximum is 2^31 and SHALL NOT wrap.
REQ-023 The accumulator RAM SHALL be NofBins x 40 bits, addressed by index_i.
REQ-024 In frame 0, the power SHALL be written to the RAM, overwriting the previous content; in later frames, the RAM SHALL perform read-modify-write acc += power.
REQ-025 The RMW pipeline SHALL accept one sample per cycle with no stall.
REQ-026 Back-to-back frames (bin NofBins-1 followed by bin 0 on the next cycle) SHALL accumulate correctly, with no read-after-write hazard.
REQ-027 In ACCUM, a dv_i with index_i different from the expected index SHALL set err_o.
REQ-028 After such a mismatch, the sample SHALL still be used at address index_i, and the expected index SHALL resync to index_i+1.
REQ-029 A frame SHALL end on a dv_i with index_i = NofBins-1, which increments the frame counter.
REQ-030 When the frame counter reaches the effective nof_frames, the state SHALL move to READOUT once the pipeline has drained.
REQ-031 READOUT: dv_o SHALL be high for exactly NofBins consecutive cycles, for bins 0..NofBins-1 in order.
REQ-032 The first dv_o SHALL occur no more than 8 cycles after the last input dv_i.
REQ-033 Output value = acc >> shift; if any bit above bit 31 of the shifted value is set, the output SHALL saturate to 32'hFFFFFFFF.
REQ-034 READOUT: dv_i SHALL set err_o and SHALL be discarded; the RAM SHALL NOT be modified.
REQ-035 start_i in ACCUM or READOUT SHALL be ignored.
REQ-036 After the final bin is output, the state SHALL return to IDLE on the next cycle; busy_o SHALL fall on the same cycle.
REQ-037 start_i on the cycle the state returns to IDLE SHALL be accepted.

Reset
REQ-038 rst_i SHALL force state IDLE and clear the frame counter and expected index.
REQ-039 rst_i SHALL force dv_o, sof_o, busy_o and err_o to 0, and y_hi_o and y_lo_o to 0.
REQ-040 RAM contents SHALL NOT be reset; frame 0 overwrite makes them don't-care.
REQ-041 Reset in mid-ACCUM or mid-READOUT SHALL abort the run, and no further dv_o SHALL be produced.

Verification
REQ-042 nof_frames=1, shift=0, every bin re=3, im=4 -> 1024 dv_o cycles, each with y_hi=0x0000 and y_lo=0x0019, and sof_o on the first only.
REQ-043 nof_frames=4 back-to-back, bin k re=k, im=0, shift=2 -> output bin k = k*k, with err_o=0.
REQ-044 nof_frames=255, re=im=-32768, shift=0 -> every output 0xFFFFFFFF (saturated); with shift=8 -> 0x7F800000.
REQ-045 Frame with index 5 skipped (4 followed by 6) -> err_o=1, bin 6 still accumulated, readout still of 1024 bins.
REQ-046 dv_i during READOUT, and start_i during ACCUM -> err_o=1 for dv_i only, the run is unaffected, and output values are unchanged.
REQ-047 rst_i at bin 500 of READOUT -> dv_o=0 on the next cycle and state IDLE; a new start_i with nof_frames=1 gives correct fresh values.
